// File: rtl/mem_access_stage.sv
// MEM-stage load/store unit with req/ack data memory handshake.
// Stalls the pipeline during an access and drives the MEM/WB register.
module mem_access_stage #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        memRead_i,
  input  logic        memWrite_i,
  input  logic        memToReg_i,
  input  logic        regWrite_i,
  input  logic [31:0] aluResult_i,
  input  logic [31:0] rtData_i,
  input  logic [4:0]  wbAddr_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        stall_o,
  output logic        regWrite_o,
  output logic        memToReg_o,
  output logic [31:0] aluResult_o,
  output logic [31:0] memData_o,
  output logic [4:0]  wbAddr_o,
  output logic        err_o
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_e;

  state_e      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        err_q, err_d;
  logic        rw_q, rw_d;
  logic        mtr_q, mtr_d;
  logic [31:0] alu_q, alu_d;
  logic [31:0] mdata_q, mdata_d;
  logic [4:0]  wb_q, wb_d;
  logic        stall;

  logic access, aligned;
  assign access  = memRead_i | memWrite_i;
  assign aligned = (aluResult_i[1:0] == 2'b00);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    rw_d    = regWrite_i;
    mtr_d   = memToReg_i;
    alu_d   = aluResult_i;
    wb_d    = wbAddr_i;
    mdata_d = mdata_q;
    stall   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (access && !aligned) begin
          err_d = 1'b1;
          rw_d  = 1'b0;
        end else if (access) begin
          stall   = 1'b1;
          state_d = S_WAIT;
          req_d   = 1'b1;
          we_d    = memWrite_i & ~memRead_i;
          addr_d  = aluResult_i;
          wdata_d = rtData_i;
          cnt_d   = '0;
          rw_d    = 1'b0;
          mtr_d   = 1'b0;
        end
      end
      S_WAIT: begin
        if (mem_ack_i) begin
          state_d = S_IDLE;
          req_d   = 1'b0;
          if (!we_q) mdata_d = mem_rdata_i;
        end else if (cnt_q == LAST) begin
          // abort: drop the request, flag it, squash write-back
          state_d = S_IDLE;
          req_d   = 1'b0;
          err_d   = 1'b1;
          rw_d    = 1'b0;
        end else begin
          stall = 1'b1;
          cnt_d = cnt_q + 1'b1;
          rw_d  = 1'b0;
          mtr_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rw_q    <= 1'b0;
      mtr_q   <= 1'b0;
      alu_q   <= '0;
      mdata_q <= '0;
      wb_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      rw_q    <= rw_d;
      mtr_q   <= mtr_d;
      alu_q   <= alu_d;
      mdata_q <= mdata_d;
      wb_q    <= wb_d;
    end
  end

  assign mem_req_o   = req_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign stall_o     = stall;
  assign regWrite_o  = rw_q;
  assign memToReg_o  = mtr_q;
  assign aluResult_o = alu_q;
  assign memData_o   = mdata_q;
  assign wbAddr_o    = wb_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage (TIMEOUT=4).
// Table vectors for single-cycle cases plus multi-cycle access sequences.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        memRead_i, memWrite_i, memToReg_i, regWrite_i;
  logic [31:0] aluResult_i, rtData_i;
  logic [4:0]  wbAddr_i;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        stall_o, regWrite_o, memToReg_o;
  logic [31:0] aluResult_o, memData_o;
  logic [4:0]  wbAddr_o;
  logic        err_o;

  always #5 clk = ~clk;

  mem_access_stage #(.TIMEOUT(4)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .memRead_i(memRead_i), .memWrite_i(memWrite_i),
    .memToReg_i(memToReg_i), .regWrite_i(regWrite_i),
    .aluResult_i(aluResult_i), .rtData_i(rtData_i),
    .wbAddr_i(wbAddr_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .stall_o(stall_o), .regWrite_o(regWrite_o),
    .memToReg_o(memToReg_o), .aluResult_o(aluResult_o),
    .memData_o(memData_o), .wbAddr_o(wbAddr_o),
    .err_o(err_o)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        rd, wr, mtr, rw;
    logic [31:0] alu;
    logic [4:0]  wb;
    logic        e_rw, e_mtr, e_err;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", n, a, e);
    end
  endtask

  task automatic nop();
    memRead_i = 0; memWrite_i = 0; memToReg_i = 0;
    regWrite_i = 0; aluResult_i = 0; rtData_i = 0;
    wbAddr_i = 0; mem_ack_i = 0; mem_rdata_i = 0;
  endtask

  task automatic chk_zero(input string n);
    chk({n, "_req"},   32'(mem_req_o), 0);
    chk({n, "_we"},    32'(mem_we_o), 0);
    chk({n, "_addr"},  mem_addr_o, 0);
    chk({n, "_wdata"}, mem_wdata_o, 0);
    chk({n, "_stall"}, 32'(stall_o), 0);
    chk({n, "_rw"},    32'(regWrite_o), 0);
    chk({n, "_mtr"},   32'(memToReg_o), 0);
    chk({n, "_alu"},   aluResult_o, 0);
    chk({n, "_mdata"}, memData_o, 0);
    chk({n, "_wb"},    32'(wbAddr_o), 0);
    chk({n, "_err"},   32'(err_o), 0);
  endtask

  task automatic access(input string n, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic rw, input logic mtr,
                        input logic [4:0] wb, input int k,
                        input logic exp_we, input logic [31:0] rdata,
                        input logic [31:0] exp_mdata);
    int sc;
    sc = 0;
    memRead_i = rd; memWrite_i = wr; aluResult_i = a;
    rtData_i = wd; regWrite_i = rw; memToReg_i = mtr; wbAddr_i = wb;
    #1 if (stall_o) sc++;
    for (int w = 1; w <= k; w++) begin
      @(posedge clk); #1;
      chk({n, "_req"},   32'(mem_req_o), 1);
      chk({n, "_we"},    32'(mem_we_o), 32'(exp_we));
      chk({n, "_addr"},  mem_addr_o, a);
      chk({n, "_wdata"}, mem_wdata_o, wd);
      chk({n, "_bubble"}, 32'(regWrite_o), 0);
      if (w == k) begin
        mem_ack_i = 1; mem_rdata_i = rdata;
      end
      #1 if (stall_o) sc++;
    end
    @(posedge clk); #1;
    mem_ack_i = 0;
    chk({n, "_req_drop"}, 32'(mem_req_o), 0);
    chk({n, "_stall_cycles"}, 32'(sc), 32'(k));
    chk({n, "_rw_o"},  32'(regWrite_o), 32'(rw));
    chk({n, "_mtr_o"}, 32'(memToReg_o), 32'(mtr));
    chk({n, "_alu_o"}, aluResult_o, a);
    chk({n, "_wb_o"},  32'(wbAddr_o), 32'(wb));
    chk({n, "_mdata"}, memData_o, exp_mdata);
    nop();
  endtask

  initial begin
    tbl[0] = '{0, 0, 0, 1, 32'h0000_0010, 5'd5,  1, 0, 0};
    tbl[1] = '{0, 0, 0, 0, 32'hFFFF_FFFF, 5'd31, 0, 0, 0};
    tbl[2] = '{0, 0, 1, 1, 32'h8000_0004, 5'd0,  1, 1, 0};
    tbl[3] = '{1, 0, 1, 1, 32'h0000_0102, 5'd3,  0, 1, 1};
    tbl[4] = '{0, 1, 0, 0, 32'h0000_0203, 5'd0,  0, 0, 1};
    tbl[5] = '{0, 0, 0, 1, 32'h0000_0055, 5'd12, 1, 0, 1};

    nop();
    rst_i = 0;
    repeat (2) @(posedge clk);
    #1 chk_zero("reset");
    #3 rst_i = 1;
    @(posedge clk); #1;

    // reset in the middle of a WAIT
    memRead_i = 1; aluResult_i = 32'h40; regWrite_i = 1; wbAddr_i = 4;
    #1 chk("midwait_stall", 32'(stall_o), 1);
    @(posedge clk); #1;
    chk("midwait_req", 32'(mem_req_o), 1);
    nop();
    rst_i = 0;
    #1 chk_zero("rst_async");
    repeat (2) @(posedge clk);
    #1 chk_zero("rst_held");
    #3 rst_i = 1;
    @(posedge clk); #1;
    chk_zero("rst_release");

    // timeout: no ack for 4 WAIT cycles
    memRead_i = 1; memToReg_i = 1; regWrite_i = 1;
    aluResult_i = 32'h300; wbAddr_i = 9;
    #1 chk("to_stall0", 32'(stall_o), 1);
    for (int w = 1; w <= 4; w++) begin
      @(posedge clk); #1;
      chk("to_req", 32'(mem_req_o), 1);
      chk("to_bubble", 32'(regWrite_o), 0);
      #1 chk("to_stall", 32'(stall_o), (w < 4) ? 32'd1 : 32'd0);
    end
    @(posedge clk); #1;
    chk("to_req_drop", 32'(mem_req_o), 0);
    chk("to_err", 32'(err_o), 1);
    chk("to_rw_o", 32'(regWrite_o), 0);
    chk("to_alu_o", aluResult_o, 32'h300);
    chk("to_wb_o", 32'(wbAddr_o), 9);
    nop();
    repeat (2) @(posedge clk);
    #1 mem_ack_i = 1; mem_rdata_i = 32'hDEAD_BEEF;
    #1 chk("late_ack_stall", 32'(stall_o), 0);
    @(posedge clk); #1;
    mem_ack_i = 0;
    chk("late_ack_req", 32'(mem_req_o), 0);
    chk("late_ack_mdata", memData_o, 0);
    chk("late_ack_err", 32'(err_o), 1);
    @(posedge clk); #1;
    chk("late_ack_req2", 32'(mem_req_o), 0);

    rst_i = 0;
    repeat (2) @(posedge clk);
    #1 chk_zero("rst2");
    #3 rst_i = 1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      memRead_i = tbl[i].rd; memWrite_i = tbl[i].wr;
      memToReg_i = tbl[i].mtr; regWrite_i = tbl[i].rw;
      aluResult_i = tbl[i].alu; wbAddr_i = tbl[i].wb;
      rtData_i = 32'hA5A5_A5A5;
      #1 chk($sformatf("v%0d_stall", i), 32'(stall_o), 0);
      @(posedge clk); #1;
      chk($sformatf("v%0d_rw", i), 32'(regWrite_o), 32'(tbl[i].e_rw));
      chk($sformatf("v%0d_mtr", i), 32'(memToReg_o), 32'(tbl[i].e_mtr));
      chk($sformatf("v%0d_alu", i), aluResult_o, tbl[i].alu);
      chk($sformatf("v%0d_wb", i), 32'(wbAddr_o), 32'(tbl[i].wb));
      chk($sformatf("v%0d_err", i), 32'(err_o), 32'(tbl[i].e_err));
      chk($sformatf("v%0d_req", i), 32'(mem_req_o), 0);
      chk($sformatf("v%0d_mdata", i), memData_o, 0);
    end
    nop();

    access("load", 1, 0, 32'h100, 32'h0, 1, 1, 5'd7, 3, 0,
           32'hCAFE_F00D, 32'hCAFE_F00D);
    access("store", 0, 1, 32'h200, 32'h1234_5678, 0, 0, 5'd0, 1, 1,
           32'hBADB_AD00, 32'hCAFE_F00D);
    access("rdwr", 1, 1, 32'h400, 32'h1111_1111, 1, 1, 5'd2, 2, 0,
           32'h0F0F_0F0F, 32'h0F0F_0F0F);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
